// File: rtl/popcount_frame_accum_if.sv
// Stream bundle for the frame popcount accumulator: an input word stream
// (valid/ready with per-word count and frame marker) and a registered
// result stream back to the consumer.
interface popcount_frame_accum_if #(
  parameter int WORDS_LOG2 = 10,
  parameter int SUM_WIDTH  = WORDS_LOG2 + 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [5:0]            in_count;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [SUM_WIDTH-1:0]  out_sum;
  logic [WORDS_LOG2:0]   out_words;
  logic                  out_ovf;
  logic                  out_err;

  // Producer/consumer side: feeds words and accepts results.
  modport master (
    output in_valid, in_count, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_words, out_ovf, out_err
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_count, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_words, out_ovf, out_err
  );
endinterface

// File: rtl/popcount_frame_accum.sv
// Frame-level popcount accumulator. Sums per-word popcounts over a frame
// terminated by in_last and presents the total, the saturating word count
// and error flags on a registered result handshake. Counts above 32 are
// clamped to 32 and flagged; the running sum saturates instead of wrapping.
module popcount_frame_accum #(
  parameter int WORDS_LOG2 = 10,
  parameter int SUM_WIDTH  = WORDS_LOG2 + 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  popcount_frame_accum_if.slave   bus
);

  typedef enum logic {ACCUM, DONE} state_t;

  localparam logic [WORDS_LOG2:0]  MAX_WORDS = {1'b1, {WORDS_LOG2{1'b0}}};
  localparam logic [SUM_WIDTH-1:0] SUM_MAX   = '1;

  state_t                 state_q, state_d;
  logic [SUM_WIDTH-1:0]   acc_q, acc_d;
  logic [WORDS_LOG2:0]    wcnt_q, wcnt_d;
  logic                   err_q, err_d;
  logic                   ovf_q, ovf_d;
  logic [SUM_WIDTH-1:0]   outSum_q, outSum_d;
  logic [WORDS_LOG2:0]    outWords_q, outWords_d;
  logic                   outOvf_q, outOvf_d;
  logic                   outErr_q, outErr_d;

  logic                   inReady;
  logic                   outValid;
  logic                   accept;
  logic                   cntIllegal;
  logic [5:0]             cntClamped;
  logic [SUM_WIDTH:0]     sumWide;
  logic [SUM_WIDTH-1:0]   accNext;
  logic                   wcntFull;
  logic [WORDS_LOG2:0]    wcntNext;
  logic                   errNext;
  logic                   ovfNext;

  // State register; reset discards any partial frame or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: close the frame on an in_last accept, reopen on result handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && bus.in_last) state_d = DONE;
      DONE:    if (bus.out_ready)         state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Handshake outputs depend on state only, so in_ready never sees out_ready.
  always_comb begin
    inReady  = (state_q == ACCUM);
    outValid = (state_q == DONE);
  end

  // Per-word arithmetic: clamp the count, saturate the sum and the word count.
  always_comb begin
    accept     = bus.in_valid && inReady;
    cntIllegal = (bus.in_count > 6'd32);
    cntClamped = cntIllegal ? 6'd32 : bus.in_count;
    sumWide    = {1'b0, acc_q} + {{(SUM_WIDTH-5){1'b0}}, cntClamped};
    accNext    = sumWide[SUM_WIDTH] ? SUM_MAX : sumWide[SUM_WIDTH-1:0];
    wcntFull   = (wcnt_q == MAX_WORDS);
    wcntNext   = wcntFull ? wcnt_q : wcnt_q + (WORDS_LOG2+1)'(1);
    errNext    = err_q | cntIllegal;
    ovfNext    = ovf_q | wcntFull;
  end

  // Next values for the accumulators and result registers; a last word loads
  // the result including itself and clears the accumulators in the same edge.
  always_comb begin
    acc_d      = acc_q;
    wcnt_d     = wcnt_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    outSum_d   = outSum_q;
    outWords_d = outWords_q;
    outOvf_d   = outOvf_q;
    outErr_d   = outErr_q;
    if (accept) begin
      if (bus.in_last) begin
        outSum_d   = accNext;
        outWords_d = wcntNext;
        outOvf_d   = ovfNext;
        outErr_d   = errNext;
        acc_d      = '0;
        wcnt_d     = '0;
        err_d      = 1'b0;
        ovf_d      = 1'b0;
      end else begin
        acc_d      = accNext;
        wcnt_d     = wcntNext;
        err_d      = errNext;
        ovf_d      = ovfNext;
      end
    end
  end

  // Datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      outSum_q   <= '0;
      outWords_q <= '0;
      outOvf_q   <= 1'b0;
      outErr_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      outSum_q   <= outSum_d;
      outWords_q <= outWords_d;
      outOvf_q   <= outOvf_d;
      outErr_q   <= outErr_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_sum   = outSum_q;
  assign bus.out_words = outWords_q;
  assign bus.out_ovf   = outOvf_q;
  assign bus.out_err   = outErr_q;

endmodule

// File: tb/tb_popcount_frame_accum.sv
// Self-checking bench for popcount_frame_accum: a default-size instance and a
// WORDS_LOG2=2 instance (for word/sum saturation), both compared against a
// frame-level reference model computed from the list of counts in each frame.
module tb_popcount_frame_accum;

  localparam int WL_A = 10;
  localparam int SW_A = WL_A + 6;
  localparam int WL_B = 2;
  localparam int SW_B = WL_B + 6;

  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  int expSum;
  int expWords;
  int expOvf;
  int expErr;

  popcount_frame_accum_if #(.WORDS_LOG2(WL_A), .SUM_WIDTH(SW_A)) ifA ();
  popcount_frame_accum_if #(.WORDS_LOG2(WL_B), .SUM_WIDTH(SW_B)) ifB ();

  popcount_frame_accum #(.WORDS_LOG2(WL_A), .SUM_WIDTH(SW_A)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifA)
  );

  popcount_frame_accum #(.WORDS_LOG2(WL_B), .SUM_WIDTH(SW_B)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifB)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if a handshake never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic drive(input bit useB, input logic v, input logic [5:0] c, input logic l);
    if (useB) begin
      ifB.in_valid = v; ifB.in_count = c; ifB.in_last = l;
    end else begin
      ifA.in_valid = v; ifA.in_count = c; ifA.in_last = l;
    end
  endtask

  task automatic setOutReady(input bit useB, input logic r);
    if (useB) ifB.out_ready = r;
    else      ifA.out_ready = r;
  endtask

  function automatic logic [31:0] rdInReady(input bit useB);
    return useB ? 32'(ifB.in_ready) : 32'(ifA.in_ready);
  endfunction
  function automatic logic [31:0] rdOutValid(input bit useB);
    return useB ? 32'(ifB.out_valid) : 32'(ifA.out_valid);
  endfunction
  function automatic logic [31:0] rdSum(input bit useB);
    return useB ? 32'(ifB.out_sum) : 32'(ifA.out_sum);
  endfunction
  function automatic logic [31:0] rdWords(input bit useB);
    return useB ? 32'(ifB.out_words) : 32'(ifA.out_words);
  endfunction
  function automatic logic [31:0] rdOvf(input bit useB);
    return useB ? 32'(ifB.out_ovf) : 32'(ifA.out_ovf);
  endfunction
  function automatic logic [31:0] rdErr(input bit useB);
    return useB ? 32'(ifB.out_err) : 32'(ifA.out_err);
  endfunction

  // Reference: total of clamped counts (saturated to the sum width), word count
  // saturated at 2^WORDS_LOG2, overflow when more words than that, error when
  // any count exceeds 32.
  task automatic modelFrame(input bit useB, input int counts[$]);
    int wl     = useB ? WL_B : WL_A;
    int sw     = useB ? SW_B : SW_A;
    int limit  = 1 << wl;
    int maxSum = (1 << sw) - 1;
    int total  = 0;
    int bad    = 0;
    foreach (counts[i]) begin
      total += (counts[i] > 32) ? 32 : counts[i];
      if (counts[i] > 32) bad = 1;
    end
    expSum   = (total > maxSum) ? maxSum : total;
    expWords = (counts.size() > limit) ? limit : counts.size();
    expOvf   = (counts.size() > limit) ? 1 : 0;
    expErr   = bad;
  endtask

  // Offer one word and hold it until an edge where in_ready was high.
  task automatic sendWord(input bit useB, input int cnt, input bit last);
    int waited = 0;
    drive(useB, 1'b1, 6'(cnt), last);
    while (rdInReady(useB) != 1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited == 20) check("inReadyWait", rdInReady(useB), 1);
    @(posedge clk); #1;
    drive(useB, 1'b0, 6'($urandom), 1'($urandom));
  endtask

  // Send a frame with random idle gaps; gap cycles carry junk data with valid low.
  task automatic applyStimulus(input bit useB, input int counts[$], input int gapPct, input bit markLast);
    foreach (counts[i]) begin
      while ($urandom_range(99) < gapPct) begin
        drive(useB, 1'b0, 6'($urandom), 1'($urandom));
        @(posedge clk); #1;
      end
      sendWord(useB, counts[i], markLast && (i == counts.size() - 1));
    end
  endtask

  // Compare the presented result against the model, right after the last accept.
  task automatic checkOutput(input bit useB, input string tag);
    check({tag, ".outValid"}, rdOutValid(useB), 1);
    check({tag, ".inReady"},  rdInReady(useB),  0);
    check({tag, ".sum"},      rdSum(useB),      expSum);
    check({tag, ".words"},    rdWords(useB),    expWords);
    check({tag, ".ovf"},      rdOvf(useB),      expOvf);
    check({tag, ".err"},      rdErr(useB),      expErr);
  endtask

  // Hold out_ready low for some cycles (junk on the input side), then handshake.
  task automatic consume(input bit useB, input int hold, input string tag);
    if (hold > 0) setOutReady(useB, 1'b0);
    for (int i = 0; i < hold; i++) begin
      drive(useB, 1'b1, 6'($urandom), 1'($urandom));
      @(posedge clk); #1;
      check({tag, ".holdValid"}, rdOutValid(useB), 1);
      check({tag, ".holdReady"}, rdInReady(useB),  0);
      check({tag, ".holdSum"},   rdSum(useB),      expSum);
      check({tag, ".holdWords"}, rdWords(useB),    expWords);
    end
    drive(useB, 1'b0, 6'd0, 1'b0);
    setOutReady(useB, 1'b1);
    @(posedge clk); #1;
    check({tag, ".postValid"}, rdOutValid(useB), 0);
    check({tag, ".postReady"}, rdInReady(useB),  1);
    check({tag, ".keptSum"},   rdSum(useB),      expSum);
    setOutReady(useB, 1'b0);
  endtask

  task automatic runFrame(input bit useB, input int counts[$], input int gapPct, input int hold, input string tag);
    modelFrame(useB, counts);
    applyStimulus(useB, counts, gapPct, 1'b1);
    checkOutput(useB, tag);
    consume(useB, hold, tag);
  endtask

  initial begin
    int q[$];
    int n;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 1'b0);
    drive(1'b1, 1'b0, 6'd0, 1'b0);
    setOutReady(1'b0, 1'b0);
    setOutReady(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    check("rst.outValid", rdOutValid(1'b0), 0);
    check("rst.sum",      rdSum(1'b0),      0);
    check("rst.words",    rdWords(1'b0),    0);
    check("rst.ovf",      rdOvf(1'b0),      0);
    check("rst.err",      rdErr(1'b0),      0);
    check("rstB.outValid", rdOutValid(1'b1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.inReady", rdInReady(1'b0), 1);
    check("rstB.inReady", rdInReady(1'b1), 1);

    // Basic frame with the consumer always ready.
    $display("[TB] basic frame");
    setOutReady(1'b0, 1'b1);
    runFrame(1'b0, '{32, 0, 17, 1}, 0, 0, "basic");
    check("basic.sumConst", rdSum(1'b0), 50);

    // Single word under backpressure; junk offered while DONE must be ignored.
    $display("[TB] backpressure");
    runFrame(1'b0, '{9}, 0, 5, "bp");

    // Long frame with random idle gaps.
    $display("[TB] gapped 100-word frame");
    q.delete();
    for (int i = 0; i < 100; i++) q.push_back(32);
    runFrame(1'b0, q, 30, 1, "gap100");

    // Word-count saturation on the small instance, then a clean frame.
    $display("[TB] overflow");
    runFrame(1'b1, '{32, 32, 32, 32, 32, 32}, 10, 0, "ovf");
    runFrame(1'b1, '{1, 2}, 0, 0, "postOvf");

    // Random frames on the small instance, including sum saturation.
    $display("[TB] random small frames");
    for (int f = 0; f < 10; f++) begin
      q.delete();
      n = $urandom_range(9, 1);
      for (int i = 0; i < n; i++) q.push_back($urandom_range(40));
      runFrame(1'b1, q, 20, $urandom_range(2), "randB");
    end
    runFrame(1'b1, '{32, 32, 32, 32, 32, 32, 32, 32, 32}, 0, 0, "sumSat");

    // Illegal count handling and its clearing in the next frame.
    $display("[TB] illegal count");
    runFrame(1'b0, '{40, 3}, 0, 0, "illegal");
    runFrame(1'b0, '{3}, 0, 0, "postIllegal");

    // Random frames with back-to-back results on the default instance.
    $display("[TB] random frames");
    for (int f = 0; f < 12; f++) begin
      q.delete();
      n = $urandom_range(30, 1);
      for (int i = 0; i < n; i++) q.push_back($urandom_range(40));
      if (f % 3 == 0) setOutReady(1'b0, 1'b1);
      runFrame(1'b0, q, 20, (f % 3 == 0) ? 0 : $urandom_range(3), "randA");
    end

    // Asynchronous reset in the middle of a frame.
    $display("[TB] mid-frame reset");
    applyStimulus(1'b0, '{7, 8, 9}, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midRst.outValid", rdOutValid(1'b0), 0);
    check("midRst.inReady",  rdInReady(1'b0),  1);
    check("midRst.sum",      rdSum(1'b0),      0);
    check("midRst.words",    rdWords(1'b0),    0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midRst.noResult", rdOutValid(1'b0), 0);
    runFrame(1'b0, '{5}, 0, 0, "afterRst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
